// File: rtl/aes_inv_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one GF(2^4)
// inversion datapath. Results are held in a single registered output
// stage. done_cnt_o counts completed result handshakes and saturates at
// its maximum value.

// GF(2^4) multiplicative inverse, field polynomial x^4+x+1, with 0 -> 0.
module gf16_inv (
  input  logic [3:0] a_i,
  output logic [3:0] y_o
);

  // Fixed inverse lookup over the 16-element field
  always_comb begin
    unique case (a_i)
      4'h0: y_o = 4'h0;
      4'h1: y_o = 4'h1;
      4'h2: y_o = 4'h9;
      4'h3: y_o = 4'hE;
      4'h4: y_o = 4'hD;
      4'h5: y_o = 4'hB;
      4'h6: y_o = 4'h7;
      4'h7: y_o = 4'h6;
      4'h8: y_o = 4'hF;
      4'h9: y_o = 4'h2;
      4'hA: y_o = 4'hC;
      4'hB: y_o = 4'h5;
      4'hC: y_o = 4'hA;
      4'hD: y_o = 4'h4;
      4'hE: y_o = 4'h3;
      default: y_o = 4'h8;
    endcase
  end

endmodule

module aes_inv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [4*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 resp_valid_o,
  output logic [3:0]           resp_data_o,
  output logic [ID_W-1:0]      resp_id_o,
  input  logic                 resp_ready_i,
  output logic [15:0]          done_cnt_o
);

  logic [ID_W-1:0] rr_ptr;
  logic            out_free;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [3:0]      sel_nibble;
  logic [3:0]      inv_nibble;
  logic            req_fire;
  logic            resp_fire;

  assign out_free  = !resp_valid_o || resp_ready_i;
  assign resp_fire = resp_valid_o && resp_ready_i;

  // Round-robin search: first asserted valid at or after rr_ptr, wrapping.
  // The index wraps by ID_W-bit overflow since NUM_REQ == 2**ID_W.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + ID_W'(i);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign req_ready_o = (gnt_found && out_free) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign req_fire    = gnt_found && out_free;

  // Route the granted requester's nibble into the shared inverter
  always_comb begin
    sel_nibble = req_data_i[4*gnt_id +: 4];
  end

  gf16_inv u_gf16_inv (
    .a_i (sel_nibble),
    .y_o (inv_nibble)
  );

  // Output stage: load on request handshake, clear when drained, else hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_id_o    <= '0;
      rr_ptr       <= '0;
    end else if (req_fire) begin
      resp_valid_o <= 1'b1;
      resp_data_o  <= inv_nibble;
      resp_id_o    <= gnt_id;
      rr_ptr       <= gnt_id + ID_W'(1);
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
  end

  // Saturating count of result handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_cnt_o <= '0;
    end else if (resp_fire && (done_cnt_o != '1)) begin
      done_cnt_o <= done_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_inv_arbiter.sv
// Bench for aes_inv_arbiter: a reference model at each falling edge
// predicts grants, pushes expected results on request handshakes and pops
// them on result handshakes; directed phases cover the main scenarios.
module tb_aes_inv_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        resp_valid_o;
  logic [3:0]  resp_data_o;
  logic [1:0]  resp_id_o;
  logic        resp_ready_i;
  logic [15:0] done_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] sb[$];
  logic       m_valid = 1'b0;
  int         m_ptr   = 0;
  int         m_done  = 0;

  aes_inv_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_id_o    (resp_id_o),
    .resp_ready_i (resp_ready_i),
    .done_cnt_o   (done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    r = '0;
    for (int b = 1; b < 16; b++)
      if (gf_mul(a, 4'(b)) == 4'h1) r = 4'(b);
    return r;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle
  always @(negedge clk_i) begin
    logic       out_free;
    logic       found;
    int         g;
    logic [3:0] exp_rdy;
    logic [5:0] e;
    if (!rst_ni) begin
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
      m_done  = 0;
    end else begin
      check_eq("resp_valid", 32'(resp_valid_o), 32'(m_valid));
      check_eq("done_cnt", 32'(done_cnt_o), 32'(m_done));
      out_free = !m_valid || resp_ready_i;
      found = 1'b0;
      g = 0;
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (!found && req_valid_i[k]) begin
          found = 1'b1;
          g = k;
        end
      end
      exp_rdy = (found && out_free) ? 4'(1 << g) : 4'h0;
      check_eq("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      if (m_valid && resp_ready_i) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("resp_id", 32'(resp_id_o), 32'(e[5:4]));
          check_eq("resp_data", 32'(resp_data_o), 32'(e[3:0]));
        end
        if (m_done != 65535) m_done++;
      end
      if (exp_rdy != 4'h0) begin
        sb.push_back({2'(g), gf_inv(req_data_i[4*g +: 4])});
        m_ptr   = (g + 1) % 4;
        m_valid = 1'b1;
      end else if (resp_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic r);
    req_valid_i  = v;
    req_data_i   = d;
    resp_ready_i = r;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    #1;
    check_eq("rst_valid", 32'(resp_valid_o), 32'd0);
    check_eq("rst_data", 32'(resp_data_o), 32'd0);
    check_eq("rst_id", 32'(resp_id_o), 32'd0);
    check_eq("rst_done", 32'(done_cnt_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(4'h0, 16'h0, 1'b0);
    #2;
    pulse_reset();

    // Single request on requester 1, nibble 2
    drive(4'b0010, 16'h0020, 1'b1);
    step();
    check_eq("single_valid", 32'(resp_valid_o), 32'd1);
    check_eq("single_data", 32'(resp_data_o), 32'h9);
    check_eq("single_id", 32'(resp_id_o), 32'd1);
    drive(4'h0, 16'h0, 1'b1);
    step();
    check_eq("single_done", 32'(done_cnt_o), 32'd1);

    // Inverse sweep on requester 0
    for (int n = 0; n < 16; n++) begin
      drive(4'b0001, 16'(n), 1'b1);
      step();
      if (n != 0) check_eq("sweep_prod", 32'(gf_mul(4'(n), resp_data_o)), 32'd1);
      if (n == 0)  check_eq("sweep_0", 32'(resp_data_o), 32'h0);
      if (n == 1)  check_eq("sweep_1", 32'(resp_data_o), 32'h1);
      if (n == 2)  check_eq("sweep_2", 32'(resp_data_o), 32'h9);
      if (n == 15) check_eq("sweep_F", 32'(resp_data_o), 32'h8);
    end
    drive(4'h0, 16'h0, 1'b1);
    step();

    // Fairness from reset with all requesters valid
    pulse_reset();
    for (int j = 0; j < 12; j++) begin
      drive(4'b1111, 16'($urandom), 1'b1);
      step();
      check_eq("fair_id", 32'(resp_id_o), 32'(j % 4));
      check_eq("fair_valid", 32'(resp_valid_o), 32'd1);
    end
    drive(4'h0, 16'h0, 1'b1);
    step();
    step();

    // Backpressure: hold inverse of 3 from requester 2 for five cycles
    drive(4'b0100, 16'h0300, 1'b1);
    step();
    drive(4'b1000, 16'h7300, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step();
      check_eq("bp_data", 32'(resp_data_o), 32'hE);
      check_eq("bp_id", 32'(resp_id_o), 32'd2);
      check_eq("bp_ready", 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(req_ready_o), 32'b1000);
    step();
    check_eq("bp_next_id", 32'(resp_id_o), 32'd3);
    check_eq("bp_next_data", 32'(resp_data_o), 32'h6);
    drive(4'h0, 16'h0, 1'b1);
    step();
    step();

    // Reset mid-operation with rr_ptr at 2 and a result pending
    drive(4'b0010, 16'h0050, 1'b1);
    step();
    drive(4'h0, 16'h0, 1'b0);
    pulse_reset();
    drive(4'b1001, 16'h2003, 1'b1);
    #1;
    check_eq("post_rst_ready", 32'(req_ready_o), 32'b0001);
    step();
    check_eq("post_rst_id", 32'(resp_id_o), 32'd0);
    check_eq("post_rst_data", 32'(resp_data_o), 32'hE);

    // Counter saturation
    for (int j = 0; j < 65600; j++) begin
      drive(4'b1111, 16'($urandom), 1'b1);
      step();
    end
    check_eq("sat_cnt", 32'(done_cnt_o), 32'hFFFF);
    for (int j = 0; j < 4; j++) step();
    check_eq("sat_hold", 32'(done_cnt_o), 32'hFFFF);

    drive(4'h0, 16'h0, 1'b1);
    step();
    step();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_arbiter.md
AES_INV_ARBITER -- requirements
Module: aes_inv_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one GF(2^4) inversion datapath; it is fixed at 4 in this revision.
REQ-002 The block SHALL have parameter ID_W, default 2, giving the requester-index width (log2 NUM_REQ).
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-006 req_data_i  input  4*NUM_REQ  per-requester nibble; requester k uses bits [4k+3:4k].
REQ-007 req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 resp_valid_o  output  1  registered result valid.
REQ-009 resp_data_o  output  4  GF(2^4) multiplicative inverse of the accepted nibble.
REQ-010 resp_id_o  output  ID_W  index of the requester that owns resp_data_o.
REQ-011 resp_ready_i  input  1  downstream accept of the result.
REQ-012 done_cnt_o  output  16  count of completed result handshakes.

Function
REQ-013 The block SHALL contain exactly one instance of the team's GF(2^4) inversion unit (field polynomial x^4+x+1; 0 maps to 0), shared by all requesters.
REQ-014 The output stage SHALL be free (out_free) when resp_valid_o=0 or resp_ready_i=1.
REQ-015 Arbitration SHALL be round-robin: among asserted req_valid_i, the grant goes to the first index at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-016 req_ready_o[k] SHALL be 1 only when k is granted and out_free=1; it is combinational and SHALL NOT depend on req_data_i.
REQ-017 A request handshake on k (req_valid_i[k] & req_ready_o[k]) SHALL, at the next edge, load resp_data_o with the inverse of requester k's nibble, load resp_id_o with k, and set resp_valid_o=1.
REQ-018 Latency from request handshake to resp_valid_o SHALL be exactly 1 cycle; throughput SHALL be one result per cycle while resp_ready_i=1.
REQ-019 On a request handshake on k, rr_ptr SHALL become (k+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-020 When resp_valid_o=1 and resp_ready_i=0, resp_valid_o, resp_data_o, resp_id_o and all req_ready_o SHALL be held (req_ready_o=0).
REQ-021 When resp_valid_o=1, resp_ready_i=1 and no new request handshake occurs, resp_valid_o SHALL clear at the next edge.
REQ-022 A simultaneous result handshake and request handshake SHALL replace the result back-to-back with no bubble.
REQ-023 done_cnt_o SHALL increment by 1 per result handshake (resp_valid_o & resp_ready_i), saturating at 16'hFFFF.
REQ-024 A requester that drops req_valid_i before its handshake SHALL lose no state and SHALL not be served.

Reset
REQ-025 While rst_ni=0, regardless of clock: resp_valid_o=0, resp_data_o=0, resp_id_o=0, rr_ptr=0, done_cnt_o=0.
REQ-026 Reset asserted mid-transfer SHALL discard any pending result; after release, arbitration SHALL restart from requester 0.

Verification
REQ-027 Single request: req_valid_i=4'b0010, nibble 4'h2 on requester 1, resp_ready_i=1 -> next cycle resp_valid_o=1, resp_data_o=4'h9, resp_id_o=1, done_cnt_o=1 one cycle later.
REQ-028 Inverse table: sweep nibbles 0..F on requester 0 -> 0->0, 1->1, 2->9, F->8; every nonzero x satisfies x*resp=1 in GF(2^4).
REQ-029 Fairness: all four valid continuously after reset, resp_ready_i=1 -> resp_id_o sequence 0,1,2,3,0,1,... with one result per cycle.
REQ-030 Backpressure: resp_ready_i=0 for 5 cycles with a result held -> resp_data_o and resp_id_o stable, req_ready_o=0, done_cnt_o unchanged; on release, the next grant issues in the same cycle.
REQ-031 Reset mid-operation: rst_ni pulsed low while resp_valid_o=1 and rr_ptr=2 -> outputs immediately 0; after release with requesters 0 and 3 valid, requester 0 is granted first.
REQ-032 Counter saturation: force 65535 completions -> done_cnt_o stays 16'hFFFF on further handshakes.
